// File: rtl/cpu6_memresp.sv
// Memory responder for the cpu6 core: one word RAM serving fetch, load and store ports,
// with a FIFO store buffer that shares the RAM write port with the program loader.
module cpu6_memresp #(
  parameter int XLEN     = 32,
  parameter int AW       = 10,
  parameter int SB_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [XLEN-1:0]               fetchaddr,
  output logic [XLEN-1:0]               instr,
  input  logic                          memwriteM,
  input  logic [XLEN-1:0]               dataaddr,
  input  logic [XLEN-1:0]               writedata,
  output logic [XLEN-1:0]               readdata,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [XLEN-1:0]               ld_addr,
  input  logic [XLEN-1:0]               ld_data,
  output logic [$clog2(SB_DEPTH):0]     sb_count
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  // Source of the single RAM write this cycle.
  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_LOAD  = 2'd1,
    WR_DRAIN = 2'd2
  } wr_sel_e;

  logic [XLEN-1:0] r_mem [2**AW];

  logic [AW-1:0]   r_sb_addr [SB_DEPTH];
  logic [XLEN-1:0] r_sb_data [SB_DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic [AW-1:0]   w_faddr;
  logic [AW-1:0]   w_daddr;
  logic [AW-1:0]   w_laddr;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  wr_sel_e         w_wr_sel;
  logic            w_fwd_hit;
  logic [XLEN-1:0] w_fwd_data;
  logic            w_unused;

  assign w_faddr = fetchaddr[AW+1:2];
  assign w_daddr = dataaddr[AW+1:2];
  assign w_laddr = ld_addr[AW+1:2];
  assign w_unused = ^{fetchaddr[XLEN-1:AW+2], fetchaddr[1:0],
                      dataaddr[XLEN-1:AW+2], dataaddr[1:0],
                      ld_addr[XLEN-1:AW+2], ld_addr[1:0]};

  assign w_full   = (r_count == CW'(SB_DEPTH));
  assign ld_ready = !w_full;
  assign sb_count = r_count;

  assign instr = r_mem[w_faddr];

  // Walk oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if ((CW'(i) < r_count) && (r_sb_addr[r_head + PW'(i)] == w_daddr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_sb_data[r_head + PW'(i)];
      end
    end
  end

  assign readdata = w_fwd_hit ? w_fwd_data : r_mem[w_daddr];

  // A full buffer always drains, so the loader can never starve the core of store slots.
  always_comb begin
    w_wr_sel = WR_IDLE;
    if (w_full) begin
      w_wr_sel = WR_DRAIN;
    end else if (ld_valid) begin
      w_wr_sel = WR_LOAD;
    end else if (r_count != '0) begin
      w_wr_sel = WR_DRAIN;
    end
  end

  assign w_push = memwriteM;
  assign w_pop  = (w_wr_sel == WR_DRAIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_sb_addr[r_tail] <= w_daddr;
      r_sb_data[r_tail] <= writedata;
    end
  end

  // Reset suppresses any write, which also aborts a drain in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      case (w_wr_sel)
        WR_LOAD:  r_mem[w_laddr]         <= ld_data;
        WR_DRAIN: r_mem[r_sb_addr[r_head]] <= r_sb_data[r_head];
        default:  ;
      endcase
    end
  end

endmodule
